mbledhesi_serik: RTL

MBLEDHESI_SERIK -- requirements
Module: mbledhesi_serik

---
 rtl/mbledhesi_serik.sv | 110 +++++++++++
 1 files changed

// File: rtl/mbledhesi_serik.sv
// Bit-serial adder/subtractor: one full-adder cell walks the operands LSB first,
// one bit per clock, and presents SUM/COUT/OVF with a one-cycle DONE pulse.
module mbledhesi_serik #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               c_q, c_d;
  logic               cout_q, cout_d;
  logic               cin_msb_q, cin_msb_d;

  // The single full-adder cell shared by every bit position.
  logic fa_s, fa_co;
  assign fa_s  = a_q[0] ^ b_q[0] ^ c_q;
  assign fa_co = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    c_d       = c_q;
    cout_d    = cout_q;
    cin_msb_d = cin_msb_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_RUN;
          a_d     = A;
          // Subtraction as A + ~B + 1: the +1 enters through the initial carry.
          b_d     = SUB ? ~B : B;
          c_d     = SUB;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        res_d = {fa_s, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = fa_co;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          // Outputs are separate from the working registers so they stay frozen
          // through the next operation until its result is ready.
          cin_msb_d = c_q;
          sum_d     = {fa_s, res_q[WIDTH-1:1]};
          cout_d    = fa_co;
          state_d   = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      c_q       <= 1'b0;
      cout_q    <= 1'b0;
      cin_msb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      c_q       <= c_d;
      cout_q    <= cout_d;
      cin_msb_q <= cin_msb_d;
    end
  end

  assign BUSY = (state_q == S_RUN);
  assign DONE = (state_q == S_FIN);
  assign SUM  = sum_q;
  assign COUT = cout_q;
  assign OVF  = cout_q ^ cin_msb_q;

endmodule
